// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD receiver and the CPU-side driver:
// command codes, controller states and the blank character.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FILL = 2'd2
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPLAY = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [7:0] SPACE_CHAR  = 8'h20;
  localparam int         DDRAM_DEPTH = 32;
  localparam int         CNT_W       = 8;

  // Commands are classified by their most significant set bit; returns that bit one-hot.
  function automatic logic [7:0] cmd_msb(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) r = 8'(1) << i;
    end
    return r;
  endfunction

  function automatic logic [4:0] step_addr(input logic [4:0] a, input logic up);
    return up ? a + 5'd1 : a - 5'd1;
  endfunction

endpackage

// File: rtl/lcd_receiver.sv
// HD44780-style LCD controller model: latches CPU strobes, decodes commands,
// holds a 32-byte DDRAM and reports busy/overrun to the host.
module lcd_receiver
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lcd_data,
  input  logic [1:0] lcd_ctrl,
  input  logic       lcd_enable,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       increment,
  output logic       two_line,
  output logic       busy,
  output logic       overrun
);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       fill_addr_q, fill_addr_d;
  logic [4:0]       cursor_q, cursor_d;
  logic             increment_q, increment_d;
  logic             display_on_q, display_on_d;
  logic             cursor_on_q, cursor_on_d;
  logic             blink_on_q, blink_on_d;
  logic             two_line_q, two_line_d;
  logic             overrun_q, overrun_d;
  logic             en_q;
  logic [7:0]       data_q;
  logic [1:0]       ctrl_q;
  logic [7:0]       ddram_q [DDRAM_DEPTH];

  logic             fall;
  logic             we;
  logic [4:0]       waddr;
  logic [7:0]       wdata;

  assign fall = en_q & ~lcd_enable;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_addr_d  = fill_addr_q;
    cursor_d     = cursor_q;
    increment_d  = increment_q;
    display_on_d = display_on_q;
    cursor_on_d  = cursor_on_q;
    blink_on_d   = blink_on_q;
    two_line_d   = two_line_q;
    overrun_d    = overrun_q;
    we           = 1'b0;
    waddr        = cursor_q;
    wdata        = data_q;

    case (state_q)
      ST_IDLE: begin
        if (fall && !ctrl_q[1]) begin
          if (ctrl_q[0]) begin
            we       = 1'b1;
            cursor_d = step_addr(cursor_q, increment_q);
            state_d  = ST_BUSY;
            cnt_d    = CNT_W'(BUSY_CYCLES);
          end else begin
            // Everything but no-op, clear and home shares the short busy period.
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(BUSY_CYCLES);
            case (cmd_msb(data_q))
              CMD_CLEAR: begin
                state_d     = ST_FILL;
                fill_addr_d = '0;
                cnt_d       = CNT_W'(CLEAR_CYCLES);
              end
              CMD_HOME: begin
                cursor_d = '0;
                cnt_d    = CNT_W'(CLEAR_CYCLES);
              end
              CMD_ENTRY:   increment_d = data_q[1];
              CMD_DISPLAY: begin
                display_on_d = data_q[2];
                cursor_on_d  = data_q[1];
                blink_on_d   = data_q[0];
              end
              CMD_SHIFT: begin
                if (!data_q[3]) cursor_d = step_addr(cursor_q, data_q[2]);
              end
              CMD_FUNC:  two_line_d = data_q[3];
              CMD_CGRAM: ;
              CMD_DDRAM: cursor_d = {data_q[6], data_q[3:0]};
              default:   state_d = ST_IDLE;
            endcase
          end
        end
      end
      ST_BUSY: begin
        if (fall) overrun_d = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FILL: begin
        if (fall) overrun_d = 1'b1;
        we          = 1'b1;
        waddr       = fill_addr_q;
        wdata       = SPACE_CHAR;
        fill_addr_d = fill_addr_q + 5'd1;
        cnt_d       = cnt_q - CNT_W'(1);
        // A reset-initiated fill is loaded with exactly 32 counts, so it lands in IDLE.
        if (fill_addr_q == 5'(DDRAM_DEPTH - 1)) begin
          cursor_d    = '0;
          increment_d = 1'b1;
          state_d     = (cnt_q == CNT_W'(1)) ? ST_IDLE : ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      cnt_q        <= CNT_W'(DDRAM_DEPTH);
      fill_addr_q  <= '0;
      cursor_q     <= '0;
      increment_q  <= 1'b1;
      display_on_q <= 1'b0;
      cursor_on_q  <= 1'b0;
      blink_on_q   <= 1'b0;
      two_line_q   <= 1'b0;
      overrun_q    <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_addr_q  <= fill_addr_d;
      cursor_q     <= cursor_d;
      increment_q  <= increment_d;
      display_on_q <= display_on_d;
      cursor_on_q  <= cursor_on_d;
      blink_on_q   <= blink_on_d;
      two_line_q   <= two_line_d;
      overrun_q    <= overrun_d;
      en_q         <= lcd_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (lcd_enable) begin
      data_q <= lcd_data;
      ctrl_q <= lcd_ctrl;
    end
    if (we && !rst) ddram_q[waddr] <= wdata;
  end

  assign rd_char    = ddram_q[rd_addr];
  assign cursor     = cursor_q;
  assign display_on = display_on_q;
  assign cursor_on  = cursor_on_q;
  assign blink_on   = blink_on_q;
  assign increment  = increment_q;
  assign two_line   = two_line_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;

endmodule
